// File: rtl/cpu_clock_pkg.sv
// Shared constants and the sequencer state encoding for the CPU clock run/step/halt controller.
package cpu_clock_pkg;

    localparam int unsigned SEQ_STATE_W   = 3;
    localparam int unsigned CYCLE_COUNT_W = 32;

    typedef enum logic [SEQ_STATE_W-1:0] {
        STOP    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        RELEASE = 3'd3,
        HALT    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/cpu_clock_sequencer_if.sv
// Board-side controls and CPU-side clock outputs of the CPU clock sequencer.
interface cpu_clock_sequencer_if #(
    parameter int unsigned DIV_WIDTH = 28
);

    logic                                     run_switch;
    logic                                     step_key_n;
    logic [DIV_WIDTH-1:0]                     divisor;
    logic                                     divisor_load;
    logic                                     halt_request;
    logic                                     cpu_clock_enable;
    logic                                     cpu_clock_led;
    logic [cpu_clock_pkg::SEQ_STATE_W-1:0]    seq_state;
    logic [cpu_clock_pkg::CYCLE_COUNT_W-1:0]  cycle_count;

    // Board / CPU side: drives the controls, observes the clock outputs.
    modport master (
        output run_switch, step_key_n, divisor, divisor_load, halt_request,
        input  cpu_clock_enable, cpu_clock_led, seq_state, cycle_count
    );

    // Sequencer side.
    modport slave (
        input  run_switch, step_key_n, divisor, divisor_load, halt_request,
        output cpu_clock_enable, cpu_clock_led, seq_state, cycle_count
    );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stable-count filter for an active-low push key.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flip the accepted level on the Nth consecutive differing sample; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign key_level   = level_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Run/step/halt sequencer producing a divided one-cycle CPU clock enable and an LED square wave.
// Optional: define CYCLE_COUNTER_EN to count issued enable pulses on cycle_count.
module cpu_clock_sequencer
    import cpu_clock_pkg::*;
#(
    parameter int unsigned          DIV_WIDTH       = 28,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIVISOR = DIV_WIDTH'(10_000_000),
    parameter int unsigned          DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    cpu_clock_sequencer_if.slave  bus
);

    seq_state_e           state_q, state_d;
    logic                 run_s1_q, run_s2_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_m1_c;
    logic                 en_q, en_d;
    logic                 led_q, led_d;
    logic                 key_level;
    logic                 press_pulse;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .key_raw_n   (bus.step_key_n),
        .key_level   (key_level),
        .press_pulse (press_pulse)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STOP;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            cnt_q    <= '0;
            div_q    <= DEFAULT_DIVISOR;
            en_q     <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_s1_q <= bus.run_switch;
            run_s2_q <= run_s1_q;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            en_q     <= en_d;
            led_q    <= led_d;
        end
    end

    // A divisor of 0 would never wrap, so it is clamped to 1 like a divisor of 1.
    always_comb begin
        div_d = div_q;
        if (bus.divisor_load) begin
            div_d = (bus.divisor <= DIV_WIDTH'(1)) ? DIV_WIDTH'(1) : bus.divisor;
        end
    end

    assign div_m1_c = div_q - DIV_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        case (state_q)
            STOP: begin
                cnt_d = '0;
                if (run_s2_q) begin
                    state_d = RUN;
                end else if (press_pulse) begin
                    state_d = STEP;
                    en_d    = 1'b1;
                end
            end
            RUN: begin
                // >= rather than == so a shortened divisor wraps a count already past it.
                if (cnt_q >= div_m1_c) begin
                    cnt_d = '0;
                    en_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
                if (bus.halt_request) begin
                    state_d = HALT;
                    cnt_d   = '0;
                end else if (!run_s2_q) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
            STEP: begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                cnt_d = '0;
                if (key_level) begin
                    state_d = run_s2_q ? RUN : STOP;
                end
            end
            HALT: begin
                cnt_d = '0;
                if (!run_s2_q) begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = STOP;
                cnt_d   = '0;
            end
        endcase
    end

    assign led_d = led_q ^ en_d;

`ifdef CYCLE_COUNTER_EN
    logic [CYCLE_COUNT_W-1:0] cycle_cnt_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q <= '0;
        end else if (en_q) begin
            cycle_cnt_q <= cycle_cnt_q + CYCLE_COUNT_W'(1);
        end
    end

    assign bus.cycle_count = cycle_cnt_q;
`else
    assign bus.cycle_count = '0;
`endif

    assign bus.cpu_clock_enable = en_q;
    assign bus.cpu_clock_led    = led_q;
    assign bus.seq_state        = state_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer with DEBOUNCE_CYCLES=4 and DEFAULT_DIVISOR=5.
module tb_cpu_clock_sequencer;
    import cpu_clock_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_clock_sequencer_if #(.DIV_WIDTH(28)) bus ();

    cpu_clock_sequencer #(
        .DIV_WIDTH       (28),
        .DEFAULT_DIVISOR (28'd5),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    function automatic logic [31:0] exp_cc(input int n);
        logic [31:0] r;
        r = 32'(n);
`ifndef CYCLE_COUNTER_EN
        r = '0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.cpu_clock_enable === 1'b1) pulses++;
        end
    endtask

    // Cycles until the next enable pulse, or -1 if none within the budget.
    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.cpu_clock_enable === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] st(input logic [SEQ_STATE_W-1:0] s);
        return 32'(s);
    endfunction

    initial begin
        int p;
        int p2;
        int n;

        bus.run_switch   = 1'b0;
        bus.step_key_n   = 1'b1;
        bus.divisor      = '0;
        bus.divisor_load = 1'b0;
        bus.halt_request = 1'b0;

        // Reset held
        #12;
        check("rst_enable", 32'(bus.cpu_clock_enable), 0);
        check("rst_led",    32'(bus.cpu_clock_led), 0);
        check("rst_state",  st(bus.seq_state), st(STOP));
        check("rst_count",  bus.cycle_count, 0);

        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(100, p);
        check("idle_pulses", 32'(p), 0);
        check("idle_state",  st(bus.seq_state), st(STOP));

        // Free run
        bus.run_switch = 1'b1;
        tick();
        check("run_sync1", st(bus.seq_state), st(STOP));
        tick();
        check("run_sync2", st(bus.seq_state), st(STOP));
        tick();
        check("run_entry", st(bus.seq_state), st(RUN));
        for (int k = 1; k <= 10; k++) begin
            wait_pulse(n);
            check("run_gap", 32'(n), 5);
            check("run_led", 32'(bus.cpu_clock_led), 32'(k % 2));
        end
        tick();
        check("run_count", bus.cycle_count, exp_cc(10));
        bus.run_switch = 1'b0;
        tick(); tick(); tick();
        check("stop_state", st(bus.seq_state), st(STOP));
        check("stop_led",   32'(bus.cpu_clock_led), 0);

        // Single step: held press gives one pulse, STEP then RELEASE
        p = 0;
        bus.step_key_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.cpu_clock_enable === 1'b1) p++;
            if (i == 7) begin
                check("step_state",  st(bus.seq_state), st(STEP));
                check("step_enable", 32'(bus.cpu_clock_enable), 1);
            end
            if (i == 8) check("release_state", st(bus.seq_state), st(RELEASE));
        end
        bus.step_key_n = 1'b1;
        run_ticks(12, p2);
        check("step_pulses", 32'(p + p2), 1);
        check("step_done",   st(bus.seq_state), st(STOP));
        check("step_led",    32'(bus.cpu_clock_led), 1);

        // Two-cycle glitch is filtered
        bus.step_key_n = 1'b0;
        tick(); tick();
        bus.step_key_n = 1'b1;
        run_ticks(15, p);
        check("glitch_pulses", 32'(p), 0);
        check("glitch_state",  st(bus.seq_state), st(STOP));

        // Second press
        bus.step_key_n = 1'b0;
        run_ticks(10, p);
        bus.step_key_n = 1'b1;
        run_ticks(12, p2);
        check("step2_pulses", 32'(p + p2), 1);
        check("step2_led",    32'(bus.cpu_clock_led), 0);
        check("step2_state",  st(bus.seq_state), st(STOP));
        check("step2_count",  bus.cycle_count, exp_cc(12));

        // Halt
        bus.run_switch = 1'b1;
        tick(); tick(); tick();
        check("run2_entry", st(bus.seq_state), st(RUN));
        wait_pulse(n);
        check("run2_gap", 32'(n), 5);
        bus.halt_request = 1'b1;
        tick();
        bus.halt_request = 1'b0;
        check("halt_state",  st(bus.seq_state), st(HALT));
        check("halt_enable", 32'(bus.cpu_clock_enable), 0);
        bus.step_key_n = 1'b0;
        run_ticks(10, p);
        bus.step_key_n = 1'b1;
        run_ticks(40, p2);
        check("halt_pulses", 32'(p + p2), 0);
        check("halt_hold",   st(bus.seq_state), st(HALT));
        check("halt_led",    32'(bus.cpu_clock_led), 1);
        bus.run_switch = 1'b0;
        tick(); tick(); tick();
        check("halt_exit", st(bus.seq_state), st(STOP));
        bus.run_switch = 1'b1;
        tick(); tick(); tick();
        check("run3_entry", st(bus.seq_state), st(RUN));
        wait_pulse(n);
        check("run3_gap1", 32'(n), 5);
        wait_pulse(n);
        check("run3_gap2", 32'(n), 5);
        check("run3_led",  32'(bus.cpu_clock_led), 1);

        // Divisor 0 clamps to 1: pulse every cycle
        bus.divisor      = 28'd0;
        bus.divisor_load = 1'b1;
        tick();
        bus.divisor_load = 1'b0;
        check("div0_load_edge", 32'(bus.cpu_clock_enable), 0);
        run_ticks(8, p);
        check("div0_pulses", 32'(p), 8);

        // Divisor 8, then shorten to 3 while counter is 4
        bus.divisor      = 28'd8;
        bus.divisor_load = 1'b1;
        tick();
        bus.divisor_load = 1'b0;
        check("div8_load_edge", 32'(bus.cpu_clock_enable), 1);
        wait_pulse(n);
        check("div8_gap", 32'(n), 8);
        run_ticks(4, p);
        check("div8_quiet", 32'(p), 0);
        bus.divisor      = 28'd3;
        bus.divisor_load = 1'b1;
        tick();
        bus.divisor_load = 1'b0;
        check("div3_load_edge", 32'(bus.cpu_clock_enable), 0);
        tick();
        check("div3_wrap", 32'(bus.cpu_clock_enable), 1);
        wait_pulse(n);
        check("div3_gap1", 32'(n), 3);
        wait_pulse(n);
        check("div3_gap2", 32'(n), 3);

        // Asynchronous reset while the enable pulse is high
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(bus.cpu_clock_enable), 0);
        check("arst_led",    32'(bus.cpu_clock_led), 0);
        check("arst_state",  st(bus.seq_state), st(STOP));
        check("arst_count",  bus.cycle_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", st(bus.seq_state), st(STOP));
        tick(); tick();
        check("post_rst_run", st(bus.seq_state), st(RUN));
        wait_pulse(n);
        check("post_rst_gap", 32'(n), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
